instr_fetch_unit: RTL and testbench

- Sits directly downstream of the fetch/exec1/exec2 phase sequencer and consumes its one-hot phase outputs.
- Holds the program counter and the instruction register.
- During the fetch phase, issues the instruction read on the memory bus and feeds a stall back to the sequencer's halt input while the bus waits.
- Implements the MIPS branch delay slot and the halt on a jump to address 0.

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, instruction register, fetch read
// strobe with sequencer stall, MIPS branch delay slot and halt on jump to 0.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch,
    input  logic        exec1,
    input  logic        exec2,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    output logic [31:0] address,
    output logic        read,
    output logic        stall,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        active
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] target_reg_q, target_reg_d;
    logic        active_q, active_d;
    logic        delay_pending_q, delay_pending_d;
    logic        branch_seen_q, branch_seen_d;

    logic        capture;
    logic        commit;
    logic        fetch_done;

    always_comb begin
        // NOTE: every next-state signal defaults to its held value first so
        // no path through this block can leave one unassigned (no latches).
        pc_d            = pc_q;
        instr_d         = instr_q;
        target_reg_d    = target_reg_q;
        active_d        = active_q;
        delay_pending_d = delay_pending_q;
        branch_seen_d   = branch_seen_q;

        fetch_done = read & ~waitrequest;
        // Capture and commit both look at the pre-edge delay_pending.
        capture    = active_q & (exec1 | exec2) & branch_req & ~delay_pending_q;
        commit     = active_q & exec2;

        if (fetch_done) begin
            instr_d = readdata;
        end

        if (capture) begin
            target_reg_d  = branch_target;
            branch_seen_d = 1'b1;
        end

        if (commit) begin
            branch_seen_d = 1'b0;
            if (delay_pending_q) begin
                pc_d            = target_reg_q;
                delay_pending_d = 1'b0;
            end else begin
                pc_d            = pc_q + 32'd4;
                delay_pending_d = branch_seen_q | capture;
            end
            if (pc_d == 32'h0000_0000) begin
                active_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q            <= RESET_VECTOR;
            instr_q         <= 32'h0000_0000;
            target_reg_q    <= 32'h0000_0000;
            active_q        <= 1'b1;
            delay_pending_q <= 1'b0;
            branch_seen_q   <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            target_reg_q    <= target_reg_d;
            active_q        <= active_d;
            delay_pending_q <= delay_pending_d;
            branch_seen_q   <= branch_seen_d;
        end
    end

    // Phase inputs are undefined while reset is asserted, so both
    // handshake outputs are forced low then.
    always_comb begin
        read  = reset & fetch & active_q;
        stall = reset & ((read & waitrequest) | ~active_q);
    end

    assign address  = pc_q;
    assign pc       = pc_q;
    assign pc_plus8 = pc_q + 32'd8;
    assign instr    = instr_q;
    assign active   = active_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: reset, fetch, wait
// states, sequential flow, delay-slot branches, halt, wrap and async reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch, exec1, exec2, waitrequest, branch_req;
    logic [31:0] readdata, branch_target;
    logic [31:0] address, instr, pc, pc_plus8;
    logic        read, stall, active;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .fetch        (fetch),
        .exec1        (exec1),
        .exec2        (exec2),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .branch_req   (branch_req),
        .branch_target(branch_target),
        .address      (address),
        .read         (read),
        .stall        (stall),
        .instr        (instr),
        .pc           (pc),
        .pc_plus8     (pc_plus8),
        .active       (active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        fetch = 0; exec1 = 0; exec2 = 0; branch_req = 0;
        waitrequest = 0; readdata = 32'h0; branch_target = 32'h0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One full instruction: fetch (no wait), exec1, exec2. Starts and ends at a negedge.
    task automatic run_instr(input logic [31:0] word, input logic b1, input logic [31:0] t1,
                             input logic b2, input logic [31:0] t2);
        fetch = 1; exec1 = 0; exec2 = 0; branch_req = 0; readdata = word; waitrequest = 0;
        @(negedge clk);
        fetch = 0; exec1 = 1; branch_req = b1; branch_target = t1;
        @(negedge clk);
        exec1 = 0; exec2 = 1; branch_req = b2; branch_target = t2;
        @(negedge clk);
        exec2 = 0; branch_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        fetch = 1; waitrequest = 1;
        reset = 1'b0;
        #3;
        checks++; if (pc !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc: got %h required %h", pc, 32'hBFC00000); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h required %h", instr, 32'h0); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL reset_active: got %b required 1", active); end
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b required 0", read); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stall); end
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        fetch = 1; waitrequest = 0; readdata = 32'h24020005;
        #1;
        checks++; if (read !== 1'b1) begin errors++; $display("FAIL fetch_read: got %b required 1", read); end
        checks++; if (address !== 32'hBFC00000) begin errors++; $display("FAIL fetch_address: got %h required %h", address, 32'hBFC00000); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall: got %b required 0", stall); end
        @(negedge clk);
        checks++; if (instr !== 32'h24020005) begin errors++; $display("FAIL fetch_instr: got %h required %h", instr, 32'h24020005); end
        fetch = 0; exec1 = 1;
        @(negedge clk);
        exec1 = 0; exec2 = 1;
        @(negedge clk);
        exec2 = 0;
        checks++; if (pc !== 32'hBFC00004) begin errors++; $display("FAIL fetch_commit_pc: got %h required %h", pc, 32'hBFC00004); end
    endtask

    task automatic test_wait_states();
        int stall_cycles = 0;
        fetch = 1; waitrequest = 1; readdata = 32'h8C430000;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall === 1'b1) stall_cycles++;
            checks++; if (instr !== 32'h24020005) begin errors++; $display("FAIL wait_instr_hold[%0d]: got %h required %h", i, instr, 32'h24020005); end
            @(negedge clk);
        end
        waitrequest = 0;
        #1;
        if (stall === 1'b1) stall_cycles++;
        checks++; if (stall_cycles != 3) begin errors++; $display("FAIL wait_stall_cycles: got %0d required 3", stall_cycles); end
        @(negedge clk);
        checks++; if (instr !== 32'h8C430000) begin errors++; $display("FAIL wait_instr_load: got %h required %h", instr, 32'h8C430000); end
        fetch = 0; exec1 = 1;
        @(negedge clk);
        exec1 = 0; exec2 = 1;
        @(negedge clk);
        exec2 = 0;
        checks++; if (pc !== 32'hBFC00008) begin errors++; $display("FAIL wait_commit_pc: got %h required %h", pc, 32'hBFC00008); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'hBFC00000 + 32'(4 * i);
            fetch = 1; readdata = 32'h00000020 + 32'(i);
            #1;
            checks++; if (address !== exp_pc) begin errors++; $display("FAIL seq_address[%0d]: got %h required %h", i, address, exp_pc); end
            checks++; if (pc_plus8 !== exp_pc + 32'd8) begin errors++; $display("FAIL seq_pc_plus8[%0d]: got %h required %h", i, pc_plus8, exp_pc + 32'd8); end
            @(negedge clk);
            fetch = 0; exec1 = 1;
            @(negedge clk);
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_exec1_hold[%0d]: got %h required %h", i, pc, exp_pc); end
            exec1 = 0; exec2 = 1;
            @(negedge clk);
            exec2 = 0;
            checks++; if (pc !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_commit[%0d]: got %h required %h", i, pc, exp_pc + 32'd4); end
        end
    endtask

    task automatic test_branch();
        // Branch at BFC00010 to BFC00100; delay slot's own branch_req is ignored.
        run_instr(32'h10000003, 1'b1, 32'hBFC00100, 1'b0, 32'h0);
        checks++; if (pc !== 32'hBFC00014) begin errors++; $display("FAIL branch_delay_pc: got %h required %h", pc, 32'hBFC00014); end
        run_instr(32'h24030001, 1'b1, 32'h12345678, 1'b1, 32'h87654320);
        checks++; if (pc !== 32'hBFC00100) begin errors++; $display("FAIL branch_target_pc: got %h required %h", pc, 32'hBFC00100); end
        run_instr(32'h24040002, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pc !== 32'hBFC00104) begin errors++; $display("FAIL branch_ignored_pc: got %h required %h", pc, 32'hBFC00104); end
        // Two requests in one instruction, second on the commit edge: last wins.
        run_instr(32'h08000000, 1'b1, 32'hBFC00300, 1'b1, 32'hBFC00200);
        checks++; if (pc !== 32'hBFC00108) begin errors++; $display("FAIL branch_last_delay_pc: got %h required %h", pc, 32'hBFC00108); end
        run_instr(32'h00000000, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pc !== 32'hBFC00200) begin errors++; $display("FAIL branch_last_wins_pc: got %h required %h", pc, 32'hBFC00200); end
    endtask

    task automatic test_halt();
        reset_dut();
        for (int i = 0; i < 8; i++) run_instr(32'h00000000, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pc !== 32'hBFC00020) begin errors++; $display("FAIL halt_start_pc: got %h required %h", pc, 32'hBFC00020); end
        run_instr(32'h08000000, 1'b1, 32'h00000000, 1'b0, 32'h0);
        checks++; if (pc !== 32'hBFC00024 || active !== 1'b1) begin errors++; $display("FAIL halt_delay_slot: got pc %h active %b required pc %h active 1", pc, active, 32'hBFC00024); end
        run_instr(32'h2408000A, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (instr !== 32'h2408000A) begin errors++; $display("FAIL halt_delay_instr: got %h required %h", instr, 32'h2408000A); end
        checks++; if (pc !== 32'h0 || active !== 1'b0) begin errors++; $display("FAIL halt_state: got pc %h active %b required pc 0 active 0", pc, active); end
        fetch = 1; readdata = 32'hDEADBEEF; waitrequest = 0;
        #1;
        checks++; if (read !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL halt_outputs: got read %b stall %b required read 0 stall 1", read, stall); end
        for (int i = 0; i < 10; i++) begin
            fetch = (i % 2 == 0); exec2 = (i % 2 == 1); exec1 = (i % 3 == 0); branch_req = 1; branch_target = 32'h40;
            @(negedge clk);
            checks++; if (pc !== 32'h0 || instr !== 32'h2408000A || active !== 1'b0) begin
                errors++; $display("FAIL halt_frozen[%0d]: got pc %h instr %h active %b required pc 0 instr 2408000a active 0", i, pc, instr, active);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        reset_dut();
        run_instr(32'h08000000, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0);
        run_instr(32'h00000000, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pc !== 32'hFFFFFFF8 || pc_plus8 !== 32'h0) begin errors++; $display("FAIL wrap_fff8: got pc %h pc_plus8 %h required fffffff8 00000000", pc, pc_plus8); end
        run_instr(32'h00000000, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pc !== 32'hFFFFFFFC || pc_plus8 !== 32'h4 || active !== 1'b1) begin errors++; $display("FAIL wrap_fffc: got pc %h pc_plus8 %h active %b required fffffffc 00000004 1", pc, pc_plus8, active); end
        run_instr(32'h00000000, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pc !== 32'h0 || active !== 1'b0) begin errors++; $display("FAIL wrap_halt: got pc %h active %b required 0 0", pc, active); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        run_instr(32'h11111111, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch = 1; waitrequest = 1; readdata = 32'h22222222;
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b required 1", stall); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (pc !== 32'hBFC00000 || instr !== 32'h0 || active !== 1'b1) begin
            errors++; $display("FAIL mid_reset_state: got pc %h instr %h active %b required bfc00000 00000000 1", pc, instr, active);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %b required 0", stall); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_wait_states();
        test_sequential();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
